// File: rtl/flip_locator.sv
// Compares a read-back frame word stream against golden BRAM data and reports the first flipped bit.
// Optional macro FLIP_CORRECT_EN adds a scrub write-back port (corr_valid/corr_addr/corr_data).
module flip_locator #(
  parameter int FRAME_BASE  = 105,
  parameter int FRAME_WORDS = 101,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rd_valid,
  input  logic [12:0]      rd_addr,
  input  logic [31:0]      rd_data,
  output logic [12:0]      gold_addr,
  input  logic [31:0]      gold_data,
  output logic             busy,
  output logic             done,
  output logic             flip_found,
  output logic [11:0]      bit_location,
  output logic [12:0]      flip_addr,
  output logic [CNT_W-1:0] flip_count,
  output logic             multi_flip
`ifdef FLIP_CORRECT_EN
  ,
  output logic             corr_valid,
  output logic [12:0]      corr_addr,
  output logic [31:0]      corr_data
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  localparam logic [12:0] BASE_A = 13'(FRAME_BASE);
  localparam logic [12:0] END_A  = 13'(FRAME_BASE + FRAME_WORDS);
  localparam logic [12:0] LAST_W = 13'(FRAME_WORDS - 1);

  state_t state_q, state_d;

  logic [12:0] w;
  logic        in_win, accept, clear;

  assign w         = rd_addr - BASE_A;
  assign gold_addr = w;
  assign in_win    = (rd_addr >= BASE_A) && (rd_addr < END_A);
  assign accept    = (state_q == SCAN) && rd_valid && in_win;
  assign clear     = start && ((state_q == IDLE) || (state_q == DONE));
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Stage 1: holds the beat while the BRAM returns its golden word.
  logic        s1_vld_q;
  logic [12:0] s1_addr_q;
  logic [31:0] s1_data_q;
  logic [6:0]  s1_w_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= '0;
      s1_w_q    <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_addr_q <= rd_addr;
        s1_data_q <= rd_data;
        s1_w_q    <= w[6:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = SCAN;
      SCAN:  if (accept && (w == LAST_W)) state_d = FLUSH;
      // Nothing refills stage 1 outside SCAN, so it drains in this cycle.
      FLUSH: if (!accept) state_d = DONE;
      DONE:  state_d = start ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  logic [31:0] diff;
  logic        mism, multi_bit;
  logic [4:0]  low_b;

  assign diff      = s1_data_q ^ gold_data;
  assign mism      = s1_vld_q && (diff != 32'd0);
  assign multi_bit = ((diff & (diff - 32'd1)) != 32'd0);

  always_comb begin
    low_b = 5'd0;
    for (int i = 31; i >= 0; i--)
      if (diff[i]) low_b = 5'(i);
  end

  logic             found_q, found_d;
  logic [11:0]      loc_q, loc_d;
  logic [12:0]      faddr_q, faddr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             multi_q, multi_d;

  always_comb begin
    found_d = found_q;
    loc_d   = loc_q;
    faddr_d = faddr_q;
    cnt_d   = cnt_q;
    multi_d = multi_q;
    if (clear) begin
      found_d = 1'b0;
      loc_d   = '0;
      faddr_d = '0;
      cnt_d   = '0;
      multi_d = 1'b0;
    end else if (mism) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (multi_bit || found_q) multi_d = 1'b1;
      if (!found_q) begin
        found_d = 1'b1;
        faddr_d = s1_addr_q;
        loc_d   = {s1_w_q + 7'd1, 5'd0} + {7'd0, low_b} + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      found_q <= 1'b0;
      loc_q   <= '0;
      faddr_q <= '0;
      cnt_q   <= '0;
      multi_q <= 1'b0;
    end else begin
      found_q <= found_d;
      loc_q   <= loc_d;
      faddr_q <= faddr_d;
      cnt_q   <= cnt_d;
      multi_q <= multi_d;
    end
  end

  assign flip_found   = found_q;
  assign bit_location = loc_q;
  assign flip_addr    = faddr_q;
  assign flip_count   = cnt_q;
  assign multi_flip   = multi_q;

`ifdef FLIP_CORRECT_EN
  logic        corr_vld_q;
  logic [12:0] corr_addr_q;
  logic [31:0] corr_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_vld_q  <= 1'b0;
      corr_addr_q <= '0;
      corr_data_q <= '0;
    end else begin
      corr_vld_q <= mism;
      if (mism) begin
        corr_addr_q <= s1_addr_q;
        corr_data_q <= gold_data;
      end
    end
  end

  assign corr_valid = corr_vld_q;
  assign corr_addr  = corr_addr_q;
  assign corr_data  = corr_data_q;
`endif

endmodule

// File: tb/tb_flip_locator.sv
// Randomized-golden directed bench for flip_locator with a frame-level reference model.
// Define FLIP_CORRECT_EN for both files to also check the scrub write-back port.
module tb_flip_locator;
  localparam int FB = 105;
  localparam int FW = 101;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          rd_valid = 1'b0;
  logic [12:0]   rd_addr = '0;
  logic [31:0]   rd_data = '0;
  logic [12:0]   gold_addr;
  logic [31:0]   gold_data = '0;
  logic          busy, done, flip_found, multi_flip;
  logic [11:0]   bit_location;
  logic [12:0]   flip_addr;
  logic [CW-1:0] flip_count;
`ifdef FLIP_CORRECT_EN
  logic          corr_valid;
  logic [12:0]   corr_addr;
  logic [31:0]   corr_data;
`endif

  flip_locator #(.FRAME_BASE(FB), .FRAME_WORDS(FW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(rd_data), .gold_addr(gold_addr), .gold_data(gold_data), .busy(busy),
    .done(done), .flip_found(flip_found), .bit_location(bit_location),
    .flip_addr(flip_addr), .flip_count(flip_count), .multi_flip(multi_flip)
`ifdef FLIP_CORRECT_EN
    , .corr_valid(corr_valid), .corr_addr(corr_addr), .corr_data(corr_data)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] gold_mem [FW];
  always @(posedge clk)
    gold_data <= (gold_addr < 13'(FW)) ? gold_mem[gold_addr] : 32'hDEAD_BEEF;

  typedef struct {logic [12:0] addr; logic [31:0] data; bit st;} beat_t;
  beat_t beats[$];

  int checks = 0, errors = 0;
  int e_found, e_loc, e_faddr, e_cnt, e_multi;
  int exp_ca[$];
  logic [31:0] exp_cd[$];
  int got_ca[$];
  logic [31:0] got_cd[$];

`ifdef FLIP_CORRECT_EN
  always @(negedge clk)
    if (corr_valid) begin
      got_ca.push_back(int'(corr_addr));
      got_cd.push_back(corr_data);
    end
`endif

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame-level reference: walk beats in arrival order until the last-index word.
  task automatic model();
    e_found = 0; e_loc = 0; e_faddr = 0; e_cnt = 0; e_multi = 0;
    exp_ca.delete(); exp_cd.delete();
    foreach (beats[k]) begin
      int a = int'(beats[k].addr);
      if (a >= FB && a < FB + FW) begin
        int w = a - FB;
        logic [31:0] d = beats[k].data ^ gold_mem[w];
        if (d != 0) begin
          int lo = 0;
          while (!d[lo]) lo++;
          e_cnt++;
          if ($countones(d) > 1 || e_found != 0) e_multi = 1;
          if (e_found == 0) begin
            e_found = 1; e_faddr = a; e_loc = (w + 1) * 32 + lo + 1;
          end
          exp_ca.push_back(a);
          exp_cd.push_back(gold_mem[w]);
        end
        if (w == FW - 1) break;
      end
    end
  endtask

  task automatic clean_frame();
    beats.delete();
    for (int i = 0; i < FW; i++) beats.push_back('{13'(FB + i), gold_mem[i], 1'b0});
  endtask

  task automatic flip(int addr, logic [31:0] mask);
    foreach (beats[k]) if (int'(beats[k].addr) == addr) beats[k].data ^= mask;
  endtask

  task automatic chk_outputs_zero(string tag);
    chk({tag, ":busy"}, 32'(busy), 0);
    chk({tag, ":done"}, 32'(done), 0);
    chk({tag, ":found"}, 32'(flip_found), 0);
    chk({tag, ":loc"}, 32'(bit_location), 0);
    chk({tag, ":faddr"}, 32'(flip_addr), 0);
    chk({tag, ":cnt"}, 32'(flip_count), 0);
    chk({tag, ":multi"}, 32'(multi_flip), 0);
  endtask

  task automatic run(string tag, bit decoy);
    int n;
    model();
    got_ca.delete(); got_cd.delete();
    @(posedge clk); #1;
    start = 1'b1;
    if (decoy) begin
      rd_valid = 1'b1; rd_addr = 13'(FB + FW - 1); rd_data = ~gold_mem[FW - 1];
    end
    @(posedge clk); #1;
    start = 1'b0; rd_valid = 1'b0;
    chk({tag, ":busy"}, 32'(busy), 1);
    foreach (beats[k]) begin
      rd_valid = 1'b1; rd_addr = beats[k].addr; rd_data = beats[k].data; start = beats[k].st;
      @(posedge clk); #1;
    end
    rd_valid = 1'b0; start = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":done_lat"}, 32'(n), 1);
    chk({tag, ":found"}, 32'(flip_found), 32'(e_found));
    chk({tag, ":loc"}, 32'(bit_location), 32'(e_loc));
    chk({tag, ":faddr"}, 32'(flip_addr), 32'(e_faddr));
    chk({tag, ":cnt"}, 32'(flip_count), 32'(e_cnt));
    chk({tag, ":multi"}, 32'(multi_flip), 32'(e_multi));
    @(posedge clk); #1;
    chk({tag, ":done_pulse"}, 32'(done), 0);
    chk({tag, ":idle"}, 32'(busy), 0);
    chk({tag, ":hold_loc"}, 32'(bit_location), 32'(e_loc));
    chk({tag, ":hold_cnt"}, 32'(flip_count), 32'(e_cnt));
`ifdef FLIP_CORRECT_EN
    chk({tag, ":corr_n"}, 32'(got_ca.size()), 32'(exp_ca.size()));
    if (got_ca.size() == exp_ca.size())
      foreach (exp_ca[k]) begin
        chk({tag, ":corr_addr"}, 32'(got_ca[k]), 32'(exp_ca[k]));
        chk({tag, ":corr_data"}, got_cd[k], exp_cd[k]);
      end
`endif
  endtask

  initial begin
    for (int i = 0; i < FW; i++) gold_mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // 1: clean frame; decoy last-index beat alongside start must be ignored
    clean_frame();
    run("clean", 1'b1);

    // 2: single-bit flip
    clean_frame(); flip(110, 32'h0000_0080);
    run("single", 1'b0);

    // 3: two bits in the first word
    clean_frame(); flip(105, 32'h0000_0009);
    run("double", 1'b0);

    // 4: descending order, first flip by arrival not address
    beats.delete();
    for (int i = FW - 2; i >= 0; i--) beats.push_back('{13'(FB + i), gold_mem[i], 1'b0});
    beats.push_back('{13'(FB + FW - 1), gold_mem[FW - 1], 1'b0});
    flip(150, 32'h8000_0000); flip(120, 32'h0000_0001);
    run("desc", 1'b0);

    // 5: reset mid-scan discards partial results
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    clean_frame(); flip(110, 32'h10); flip(130, 32'h3);
    for (int k = 0; k < 50; k++) begin
      rd_valid = 1'b1; rd_addr = beats[k].addr; rd_data = beats[k].data;
      @(posedge clk); #1;
    end
    rd_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk_outputs_zero("midrst");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_outputs_zero("midrst_drain");
    clean_frame();
    run("after_rst", 1'b0);

    // 6: out-of-window garbage and a mid-scan start are ignored
    clean_frame();
    beats.insert(20, '{13'd90, 32'hFFFF_FFFF, 1'b0});
    beats.insert(40, '{13'd300, 32'h1234_5678, 1'b1});
    beats.insert(60, '{13'd90, 32'h0, 1'b1});
    run("garbage", 1'b0);

    // randomized frames: shuffled order, random flips, duplicates, garbage
    for (int r = 0; r < 4; r++) begin
      int idx[$];
      for (int i = 0; i < FW - 1; i++) idx.push_back(i);
      for (int i = FW - 2; i > 0; i--) begin
        int j = $urandom_range(i, 0);
        int t = idx[i];
        idx[i] = idx[j]; idx[j] = t;
      end
      beats.delete();
      foreach (idx[k]) beats.push_back('{13'(FB + idx[k]), gold_mem[idx[k]], 1'b0});
      for (int f = 0; f < int'($urandom_range(4, 0)); f++) begin
        int p = $urandom_range(FW - 2, 0);
        beats[p].data ^= ($urandom_range(1, 0) != 0) ? (32'h1 << $urandom_range(31, 0)) : $urandom;
      end
      beats.insert($urandom_range(FW - 2, 0), '{13'(FB + $urandom_range(FW - 2, 0)), $urandom, 1'b0});
      beats.insert($urandom_range(FW - 2, 0), '{13'($urandom_range(FB - 1, 0)), $urandom, 1'b1});
      beats.push_back('{13'(FB + FW - 1), gold_mem[FW - 1] ^ (($urandom_range(1, 0) != 0) ? 32'h4 : 32'h0), 1'b0});
      run("random", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/flip_locator.md
Name: flip_locator

Overview:
- Fault-detection counterpart of the bit-flip injector: scans a read-back configuration frame word stream and compares each word against a golden copy.
- Reports the first flipped bit as a `bit_location` code in the same encoding the injector consumes, plus the frame address, a mismatch count and a multi-flip flag.
- Sits between the readback path and the PS/controller. Golden frame data comes from an external 1-cycle-latency BRAM port.

Parameters:
- FRAME_BASE, 105: frame address of word index 0.
- FRAME_WORDS, 101: number of words in the compare window. Constraint: FRAME_WORDS*32+32 <= 4095.
- CNT_W, 16: width of flip_count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; arms a scan
- rd_valid  in  1  read-back word valid
- rd_addr  in  13  read-back word frame address
- rd_data  in  32  read-back word
- gold_addr  out  13  golden BRAM address, combinational = rd_addr - FRAME_BASE (low 13 bits)
- gold_data  in  32  golden word, valid 1 cycle after gold_addr
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of scan
- flip_found  out  1  at least one mismatching bit seen
- bit_location  out  12  encoded location of first flip
- flip_addr  out  13  rd_addr of first mismatching word
- flip_count  out  CNT_W  number of mismatching words, saturating
- multi_flip  out  1  more than one flipped bit in total

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pipeline valid bits cleared. Applies equally when rst is asserted mid-scan; any partial results are discarded.
- FSM states: IDLE, SCAN, FLUSH, DONE.
  - IDLE/DONE --start--> SCAN. On entering SCAN: flip_found, bit_location, flip_addr, flip_count and multi_flip clear to 0.
  - SCAN --> FLUSH when an in-window beat with index FRAME_WORDS-1 is accepted.
  - FLUSH --> DONE when the stage-1 pipeline is empty.
  - DONE --> IDLE next cycle.
- start while busy (SCAN/FLUSH) is ignored.
- A beat is accepted only when the FSM is SCAN and rd_valid=1. A rd_valid on the same cycle as start is ignored.
- Window: index w = rd_addr - FRAME_BASE. The beat is in-window iff FRAME_BASE <= rd_addr < FRAME_BASE+FRAME_WORDS. Out-of-window beats are dropped; they are not compared and have no effect on the FSM.
- Pipeline:
  - Beat accepted at cycle T.
  - Stage 1 (T+1) registers rd_addr, rd_data and w, and computes diff = stage1_data ^ gold_data.
  - Results register at T+2 and are visible from T+2.
  - Back-to-back beats are allowed every cycle; there is no backpressure.
- Per compared word with diff != 0:
  - flip_count increments, saturating at all-ones.
  - If flip_found was 0: set flip_found; flip_addr = rd_addr; b = index of the lowest set bit of diff; bit_location = (w+1)*32 + b + 1 (12-bit).
  - multi_flip sets if diff has more than one bit set ((diff & (diff-1)) != 0), or if flip_found was already 1.
- First flip is first in arrival order, not lowest address.
- done pulses on the cycle the last word's result becomes visible (T+2 of the index FRAME_WORDS-1 beat). Results hold until the next start or rst.
- If the index FRAME_WORDS-1 beat never arrives, the block stays in SCAN until rst.
- Duplicate addresses are each compared and counted.

Optional Feature:
- Macro: FLIP_CORRECT_EN.
- When defined, adds three outputs:
  - corr_valid  out  1
  - corr_addr  out  13
  - corr_data  out  32
- For every mismatching in-window word, corr_valid pulses one cycle at T+2 with corr_addr = that word's rd_addr and corr_data = its gold_data. These drive a scrub write-back. Reset: all three are 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. start, then 101 matching words at addrs 105..205 back-to-back -> done one pulse 2 cycles after addr 205; flip_found=0, flip_count=0, bit_location=0, multi_flip=0.
2. Same frame, addr 110 bit 7 inverted -> flip_found=1, flip_addr=110, bit_location=200, flip_count=1, multi_flip=0.
3. Addr 105 bits 0 and 3 inverted -> bit_location=33, flip_count=1, multi_flip=1.
4. Words sent in descending order, flips at 150 bit 31 then 120 bit 0 -> bit_location=1504, flip_addr=150, flip_count=2, multi_flip=1.
5. rst after 50 words of a frame containing flips -> all outputs 0 next cycle, busy=0. New start with a clean frame -> done, flip_found=0.
6. Addr 90 and 300 garbage beats interleaved, plus a start pulse mid-scan -> results equal to the clean-frame case. With FLIP_CORRECT_EN and the scenario 2 frame -> single corr_valid pulse, corr_addr=110, corr_data=golden word.
